// File: rtl/queue_arb_pkg.sv
// Shared types and the round-robin pick function for the queue add-port arbiter.
// Producer count is at most 8, so rr_pick works on a zero-extended 8-bit mask.
package queue_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 8;

  // First set bit at or above start, else the first set bit below start.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                         input logic [2:0]         start);
    logic [2:0] win;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!found && (i >= 32'(start)) && mask[3'(i)]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!found && (i < 32'(start)) && mask[3'(i)]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate/priority encode: picks the first set mask bit at or
// after start, wrapping within NUM_REQ bits.
module rr_priority_pick
  import queue_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = |mask;
    idx   = IDX_W'(rr_pick(MAX_REQ'(mask), 3'(start)));
  end

endmodule

// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter feeding one circular-queue add port from NUM_REQ producers.
// Optional QARB_LOCK_EN adds a lock input that pins arbitration to the last winner.
module queue_rr_arbiter
  import queue_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int Q_WIDTH = 8,
  parameter  int Q_SIZE  = 8,
  localparam int CNT_W   = $clog2(Q_SIZE) + 1,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef QARB_LOCK_EN
  input  logic                       lock,
`endif
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*Q_WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0]           q_remaining,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       q_add,
  output logic [Q_WIDTH-1:0]         q_data,
  output logic [IDX_W-1:0]           last_gnt
);

  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] hold_mask;
  logic               hold_active;
  logic               has_elig;
  logic               space_ok;
  logic               issue;

  // A producer whose grant is high this cycle is still presenting the word
  // just taken, so it sits out; a write already in flight consumes one slot.
  always_comb begin
    start     = (last_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : last_gnt + IDX_W'(1);
    hold_mask = hold_active ? (NUM_REQ'(1) << last_gnt) : '1;
    elig      = req & ~gnt & hold_mask;
    space_ok  = q_add ? (q_remaining > CNT_W'(1)) : (q_remaining != '0);
    issue     = has_elig && space_ok;
  end

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask  (elig),
    .start (start),
    .valid (has_elig),
    .idx   (win)
  );

`ifdef QARB_LOCK_EN
  arb_state_e state_q;
  arb_state_e state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:  if (issue && lock) state_d = HOLD;
      HOLD: if (!lock)         state_d = ARB;
    endcase
  end

  // Releasing lock reopens arbitration on the same edge that samples it low.
  assign hold_active = (state_q == HOLD) && lock;
`else
  assign hold_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      q_add    <= 1'b0;
      q_data   <= '0;
      last_gnt <= IDX_W'(NUM_REQ - 1);
    end else if (issue) begin
      gnt      <= NUM_REQ'(1) << win;
      q_add    <= 1'b1;
      q_data   <= req_data[win*Q_WIDTH +: Q_WIDTH];
      last_gnt <= win;
    end else begin
      gnt      <= '0;
      q_add    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Directed bench for queue_rr_arbiter; lock scenario runs when QARB_LOCK_EN is defined.
module tb_queue_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int Q_WIDTH = 8;
  localparam int Q_SIZE  = 8;
  localparam int CNT_W   = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*Q_WIDTH-1:0] req_data;
  logic [CNT_W-1:0]           q_remaining;
  logic [NUM_REQ-1:0]         gnt;
  logic                       q_add;
  logic [Q_WIDTH-1:0]         q_data;
  logic [1:0]                 last_gnt;
`ifdef QARB_LOCK_EN
  logic                       lock;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  queue_rr_arbiter #(.NUM_REQ(NUM_REQ), .Q_WIDTH(Q_WIDTH), .Q_SIZE(Q_SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef QARB_LOCK_EN
    .lock        (lock),
`endif
    .req         (req),
    .req_data    (req_data),
    .q_remaining (q_remaining),
    .gnt         (gnt),
    .q_add       (q_add),
    .q_data      (q_data),
    .last_gnt    (last_gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_data);
    check({tag, ".gnt"},   32'(gnt),   32'(exp_gnt));
    check({tag, ".q_add"}, 32'(q_add), 32'(|exp_gnt));
    check({tag, ".q_data"}, 32'(q_data), 32'(exp_data));
  endtask

  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [3:0] lone_gnt[4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
  logic [3:0] sp_rem  [6] = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0] sp_gnt  [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic [7:0] sp_data [6] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h11};
  logic [3:0] alt_gnt [3] = '{4'b0010, 4'b1000, 4'b0010};
  logic [7:0] alt_data[3] = '{8'h11, 8'h13, 8'h11};
  int pulses;

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    q_remaining = 4'd8;
`ifdef QARB_LOCK_EN
    lock        = 1'b0;
`endif
    tick();
    tick();
    check_out("reset", 4'b0000, 8'h00);
    check("reset.last_gnt", 32'(last_gnt), 32'd3);

    // All four requesting: strict rotation from producer 0, full throughput.
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("rr%0d", k), rr_gnt[k], rr_data[k]);
    end
    req = '0;
    tick();
    check_out("idle", 4'b0000, 8'h10);
    check("idle.last_gnt", 32'(last_gnt), 32'd0);

    // Lone requester only gets every other cycle.
    req                = 4'b0100;
    req_data[23:16]    = 8'hA5;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("lone%0d", k), lone_gnt[k], 8'hA5);
    end
    req             = '0;
    req_data[23:16] = 8'h12;
    tick();
    check("lone.last_gnt", 32'(last_gnt), 32'd2);

    // Space boundary: in-flight write counts against q_remaining.
    req    = 4'b0011;
    pulses = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      q_remaining = sp_rem[k];
      tick();
      check_out($sformatf("space%0d", k), sp_gnt[k], sp_data[k]);
      if (q_add) pulses++;
    end
    check("space.pulses", 32'(pulses), 32'd2);

    // Reset in the middle of a grant.
    q_remaining = 4'd8;
    req         = 4'b1111;
    tick();
    check_out("pre_rst", 4'b0100, 8'h12);
    rst_n = 1'b0;
    tick();
    check_out("mid_rst", 4'b0000, 8'h00);
    check("mid_rst.last_gnt", 32'(last_gnt), 32'd3);

    // Two sparse requesters after reset pointer = 3.
    rst_n = 1'b1;
    req   = 4'b1010;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("alt%0d", k), alt_gnt[k], alt_data[k]);
    end

`ifdef QARB_LOCK_EN
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0110;
    lock  = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("lock%0d", k), (k % 2 == 0) ? 4'b0010 : 4'b0000, 8'h11);
    end
    lock = 1'b0;
    tick();
    check_out("unlock", 4'b0100, 8'h12);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queue_rr_arbiter.md
QUEUE_RR_ARBITER -- requirements
Module: queue_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one circular queue add port (2..8).
REQ-002 Parameter Q_WIDTH, default 8: data width, equal to the queue's data width.
REQ-003 Parameter Q_SIZE, default 8: queue depth; CNT_W = $clog2(Q_SIZE)+1.
REQ-004 clk  input  1: single clock; all state updates on the posedge.
REQ-005 rst_n  input  1: synchronous, active-low reset, sampled on the posedge of clk.
REQ-006 req  input  NUM_REQ: per-producer request, held high until granted.
REQ-007 req_data  input  NUM_REQ*Q_WIDTH: flat data bus; slice i = [i*Q_WIDTH +: Q_WIDTH].
REQ-008 q_remaining  input  CNT_W: free-slot count from the queue.
REQ-009 gnt  output  NUM_REQ: registered one-hot grant pulse, one cycle per accepted word.
REQ-010 q_add  output  1: registered add strobe to the queue.
REQ-011 q_data  output  Q_WIDTH: registered data to the queue, valid while q_add=1.
REQ-012 last_gnt  output  $clog2(NUM_REQ): index of the most recently granted producer.
REQ-013 lock  input  1: present only when QARB_LOCK_EN is defined (see Configuration).

Function
REQ-014 Eligible set E = req & ~gnt; a producer whose grant pulse is currently high is excluded from that cycle's arbitration.
REQ-015 Space check: issue allowed iff q_remaining > (q_add ? 1 : 0); this accounts for the one in-flight write.
REQ-016 Round robin: search E starting at index (last_gnt+1) mod NUM_REQ, ascending with wrap; the first set bit wins.
REQ-017 On issue at edge t: gnt[winner]=1, q_add=1, q_data=req_data slice of the winner, last_gnt=winner, all visible in cycle t+1.
REQ-018 No issue (E empty or no space): gnt=0, q_add=0 next cycle; q_data holds its previous value; last_gnt is unchanged.
REQ-019 Latency: req sampled at edge t produces gnt/q_add in cycle t+1; a lone requester sustains 1 word per 2 cycles because of REQ-014.
REQ-020 With two or more producers continuously requesting and space available, q_add=1 every cycle (full throughput).
REQ-021 Producer handshake: on seeing gnt[i]=1, the producer drops req[i] or presents the next word by the following edge.
REQ-022 Full boundary: q_remaining=1 with q_add=1 results in no issue; q_remaining=0 never produces an issue.
REQ-023 req bits deasserting while not granted: that producer is simply skipped; there is no penalty to the pointer.
REQ-024 At most one gnt bit is ever high; q_add equals |gnt in every cycle.

Reset
REQ-025 While rst_n=0 at an edge: gnt=0, q_add=0, q_data=0, last_gnt=NUM_REQ-1, so producer 0 has first priority after reset.
REQ-026 Reset asserted mid-operation discards any pending grant; no q_add is produced in the cycle following the reset edge.

Configuration
REQ-027 Macro QARB_LOCK_EN: when defined, the lock port exists and a two-state FSM (ARB, HOLD) is compiled in.
REQ-028 FSM ARB to HOLD: an issue occurs with lock=1.
REQ-029 FSM HOLD: only producer last_gnt is eligible, with REQ-014 still applied.
REQ-030 FSM HOLD to ARB: lock=0 at an edge; the return to ARB takes effect at that edge.
REQ-031 FSM reset state is ARB.
REQ-032 Without QARB_LOCK_EN: there is no lock port and no FSM, and behaviour is pure REQ-014..REQ-024.

Structure
REQ-033 Package queue_arb_pkg holds the FSM state enum (ARB, HOLD) and a function rr_pick(mask, start) returning the winning index.
REQ-034 One sub-module, rr_priority_pick: a combinational rotate/priority-encode of NUM_REQ bits, instantiated once.

Verification
REQ-035 Reset, then req=4'b1111 with q_remaining=8 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with q_add=1 throughout.
REQ-036 Only req[2]=1, data 0xA5, q_remaining=8 -> gnt=0100 and q_data=0xA5 on alternate cycles only.
REQ-037 req=4'b0011 with q_remaining stepping 2, 1, 0 -> exactly two q_add pulses, then none while q_remaining=0.
REQ-038 req=4'b1010, last_gnt=3 -> the next grant is 0010, then 1000.
REQ-039 rst_n=0 for one edge during a grant -> the next cycle shows gnt=0, q_add=0, last_gnt=3.
REQ-040 QARB_LOCK_EN defined: lock=1 with req=4'b0110 -> only gnt=0010 is issued until lock=0, then 0100 is granted next.
